// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame scheduler: channel FSM encoding,
// channel index constants and the per-channel status bundle.
package frame_sched_pkg;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 0;
    localparam int CH_R0  = 1;
    localparam int CH_R1  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SOF  = 2'd1,
        ST_BUSY = 2'd2
    } chan_state_e;

    // Status a channel reports back to the arbiter each cycle.
    typedef struct packed {
        logic sof;   // channel is in SOF
        logic busy;  // channel is in BUSY
        logic idle;  // channel can accept a grant
        logic fin;   // BUSY ended by done this cycle
        logic tmo;   // BUSY ended by timeout this cycle
    } chan_stat_t;

endpackage

// File: rtl/frame_sched_chan.sv
// One scheduler channel: IDLE/SOF/BUSY FSM, BUSY watchdog and the
// wrapping count of frames that ended with done.
module frame_sched_chan
    import frame_sched_pkg::*;
#(
    parameter int C_TIMEOUT   = 1000000,
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   grant,
    input  logic                   done,
    output chan_stat_t             stat,
    output logic [C_CNT_WIDTH-1:0] frame_cnt
);

    localparam int TW = $clog2(C_TIMEOUT + 1);

    chan_state_e   state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          fin, tmo;

    // Next state: done beats the watchdog when both land on the last cycle.
    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        tmo       = 1'b0;
        case (state)
            ST_IDLE: if (grant) state_nxt = ST_SOF;
            ST_SOF:  state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (done) begin
                    state_nxt = ST_IDLE;
                    fin       = 1'b1;
                end else if (tmo_cnt == TW'(C_TIMEOUT - 1)) begin
                    state_nxt = ST_IDLE;
                    tmo       = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, watchdog (counts BUSY cycles already spent) and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= (state == ST_BUSY) ? tmo_cnt + TW'(1) : '0;
            if (fin) frame_cnt <= frame_cnt + C_CNT_WIDTH'(1);
        end
    end

    assign stat.sof  = (state == ST_SOF);
    assign stat.busy = (state == ST_BUSY);
    assign stat.idle = (state == ST_IDLE);
    assign stat.fin  = fin;
    assign stat.tmo  = tmo;

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: one writer and two readers sharing a mutex buffer pool.
// Writer wins arbitration; readers alternate and wait for a first frame.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int C_TIMEOUT   = 1000000,
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   w_req,
    input  logic                   r0_req,
    input  logic                   r1_req,
    input  logic                   w_done,
    input  logic                   r0_done,
    input  logic                   r1_done,
    output logic                   w_sof,
    output logic                   r0_sof,
    output logic                   r1_sof,
    output logic                   w_busy,
    output logic                   r0_busy,
    output logic                   r1_busy,
    output logic                   frame_valid,
    output logic [2:0]             err,
    input  logic [2:0]             err_clr,
    output logic [C_CNT_WIDTH-1:0] w_frame_cnt,
    output logic [C_CNT_WIDTH-1:0] r0_frame_cnt,
    output logic [C_CNT_WIDTH-1:0] r1_frame_cnt
);

    // Only the writer's completions make the pool readable.
    localparam logic [NUM_CH-1:0] FV_SRC = NUM_CH'(1) << CH_W;

    logic [NUM_CH-1:0]                  req, done, grant, cand, elig;
    logic [NUM_CH-1:0]                  sof, busy, idle, fin, tmo;
    chan_stat_t [NUM_CH-1:0]            stat;
    logic [NUM_CH-1:0][C_CNT_WIDTH-1:0] frame_cnt;
    logic                               rr_ptr;  // 0: r0 wins a tie
    logic                               any_sof;

    assign req  = {r1_req, r0_req, w_req};
    assign done = {r1_done, r0_done, w_done};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        frame_sched_chan #(
            .C_TIMEOUT   (C_TIMEOUT),
            .C_CNT_WIDTH (C_CNT_WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .grant     (grant[ch]),
            .done      (done[ch]),
            .stat      (stat[ch]),
            .frame_cnt (frame_cnt[ch])
        );
        assign sof[ch]  = stat[ch].sof;
        assign busy[ch] = stat[ch].busy;
        assign idle[ch] = stat[ch].idle;
        assign fin[ch]  = stat[ch].fin;
        assign tmo[ch]  = stat[ch].tmo;
    end

    assign elig    = {frame_valid, frame_valid, 1'b1};
    assign cand    = req & idle & elig & {NUM_CH{enable}};
    assign any_sof = |sof;

    // Single grant per cycle, none while an SOF pulse is in flight.
    always_comb begin
        grant = '0;
        if (!any_sof) begin
            if (cand[CH_W])
                grant[CH_W] = 1'b1;
            else if (cand[CH_R0] && (!cand[CH_R1] || !rr_ptr))
                grant[CH_R0] = 1'b1;
            else if (cand[CH_R1])
                grant[CH_R1] = 1'b1;
        end
    end

    // Reader round-robin pointer: the reader just served drops to lowest.
    always_ff @(posedge clk) begin
        if (reset)              rr_ptr <= 1'b0;
        else if (grant[CH_R0])  rr_ptr <= 1'b1;
        else if (grant[CH_R1])  rr_ptr <= 1'b0;
    end

    // Sticky status: frame_valid until reset, err until cleared (set wins).
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_valid <= 1'b0;
            err         <= '0;
        end else begin
            frame_valid <= frame_valid | (|(fin & FV_SRC));
            err         <= (err & ~err_clr) | tmo;
        end
    end

    assign {r1_sof, r0_sof, w_sof}    = sof;
    assign {r1_busy, r0_busy, w_busy} = busy;
    assign w_frame_cnt  = frame_cnt[CH_W];
    assign r0_frame_cnt = frame_cnt[CH_R0];
    assign r1_frame_cnt = frame_cnt[CH_R1];

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: directed scenarios then random traffic, every
// cycle compared against a transaction-level model of the scheduler.
module tb_frame_sched;

    localparam int TMO = 16;
    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic          w_req, r0_req, r1_req, w_done, r0_done, r1_done;
    logic          w_sof, r0_sof, r1_sof, w_busy, r0_busy, r1_busy;
    logic          frame_valid;
    logic [2:0]    err, err_clr;
    logic [CW-1:0] w_frame_cnt, r0_frame_cnt, r1_frame_cnt;

    int checks = 0;
    int failures = 0;

    // Model: per channel a phase (0 waiting, 1 start pulse, 2 in frame),
    // cycles spent in frame, and completed frames.
    int       m_ph[3], m_age[3], m_cnt[3];
    bit       m_fv, m_rr;
    bit [2:0] m_err;

    frame_sched #(.C_TIMEOUT(TMO), .C_CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .w_req(w_req), .r0_req(r0_req), .r1_req(r1_req),
        .w_done(w_done), .r0_done(r0_done), .r1_done(r1_done),
        .w_sof(w_sof), .r0_sof(r0_sof), .r1_sof(r1_sof),
        .w_busy(w_busy), .r0_busy(r0_busy), .r1_busy(r1_busy),
        .frame_valid(frame_valid), .err(err), .err_clr(err_clr),
        .w_frame_cnt(w_frame_cnt), .r0_frame_cnt(r0_frame_cnt),
        .r1_frame_cnt(r1_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit [2:0] rq, dn, tmo_set;
        bit       any_sof, cand[3];
        int       g;
        rq = {r1_req, r0_req, w_req};
        dn = {r1_done, r0_done, w_done};
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_ph[i] = 0; m_age[i] = 0; m_cnt[i] = 0;
            end
            m_fv = 0; m_rr = 0; m_err = '0;
            return;
        end
        any_sof = 0;
        for (int i = 0; i < 3; i++) if (m_ph[i] == 1) any_sof = 1;
        for (int i = 0; i < 3; i++)
            cand[i] = rq[i] && enable && m_ph[i] == 0 && (i == 0 || m_fv);
        g = -1;
        if (!any_sof) begin
            if (cand[0])                g = 0;
            else if (cand[1] && cand[2]) g = m_rr ? 2 : 1;
            else if (cand[1])           g = 1;
            else if (cand[2])           g = 2;
        end
        tmo_set = '0;
        for (int i = 0; i < 3; i++) begin
            if (m_ph[i] == 1) begin
                m_ph[i] = 2; m_age[i] = 0;
            end else if (m_ph[i] == 2) begin
                m_age[i]++;
                if (dn[i]) begin
                    m_ph[i] = 0;
                    m_cnt[i] = (m_cnt[i] + 1) % MOD;
                    if (i == 0) m_fv = 1;
                end else if (m_age[i] == TMO) begin
                    m_ph[i] = 0;
                    tmo_set[i] = 1;
                end
            end
        end
        if (g >= 0) begin
            m_ph[g] = 1;
            if (g == 1) m_rr = 1;
            if (g == 2) m_rr = 0;
        end
        m_err = (m_err & ~err_clr) | tmo_set;
    endtask

    task automatic compare();
        logic [2:0] es, eb;
        for (int i = 0; i < 3; i++) begin
            es[i] = (m_ph[i] == 1);
            eb[i] = (m_ph[i] == 2);
        end
        chk("sof", 32'({r1_sof, r0_sof, w_sof}), 32'(es));
        chk("busy", 32'({r1_busy, r0_busy, w_busy}), 32'(eb));
        chk("err", 32'(err), 32'(m_err));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("w_cnt", 32'(w_frame_cnt), 32'(m_cnt[0]));
        chk("r0_cnt", 32'(r0_frame_cnt), 32'(m_cnt[1]));
        chk("r1_cnt", 32'(r1_frame_cnt), 32'(m_cnt[2]));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1; enable = 1; err_clr = '0;
        w_req = 0; r0_req = 0; r1_req = 0;
        w_done = 0; r0_done = 0; r1_done = 0;
        steps(2);
        chk("rst_busy", 32'({r1_busy, r0_busy, w_busy}), 32'h0);
        reset = 0;

        // Reader alone cannot start before any writer frame.
        r0_req = 1;
        steps(6);
        chk("r0_blocked_sof", 32'(r0_sof), 32'h0);
        chk("r0_blocked_fv", 32'(frame_valid), 32'h0);
        r0_req = 0;

        // First writer frame.
        w_req = 1; step();
        chk("w_sof_lat1", 32'(w_sof), 32'h1);
        w_req = 0; steps(9);
        w_done = 1; step(); w_done = 0;
        chk("w_first_fv", 32'(frame_valid), 32'h1);
        chk("w_first_cnt", 32'(w_frame_cnt), 32'h1);

        // Simultaneous requests: w, then r0, then r1, two cycles apart.
        w_req = 1; r0_req = 1; r1_req = 1;
        step(); chk("order_w", 32'({r1_sof, r0_sof, w_sof}), 32'b001);
        step(); chk("order_gap1", 32'({r1_sof, r0_sof, w_sof}), 32'b000);
        step(); chk("order_r0", 32'({r1_sof, r0_sof, w_sof}), 32'b010);
        step(); chk("order_gap2", 32'({r1_sof, r0_sof, w_sof}), 32'b000);
        step(); chk("order_r1", 32'({r1_sof, r0_sof, w_sof}), 32'b100);
        w_req = 0; r0_req = 0; r1_req = 0;
        step();
        w_done = 1; r0_done = 1; r1_done = 1; step();
        w_done = 0; r0_done = 0; r1_done = 0; step();

        // r1 runs into the watchdog.
        r1_req = 1; step(); r1_req = 0; step();
        steps(TMO - 1);
        chk("tmo_still_busy", 32'(r1_busy), 32'h1);
        step();
        chk("tmo_idle", 32'(r1_busy), 32'h0);
        chk("tmo_err", 32'(err), 32'b100);
        chk("tmo_cnt_kept", 32'(r1_frame_cnt), 32'h1);
        err_clr = 3'b100; step(); err_clr = '0;
        chk("err_cleared", 32'(err), 32'h0);

        // enable low blocks new starts but not completions.
        w_req = 1; steps(2); w_req = 0;
        enable = 0; r0_req = 1; steps(3);
        w_done = 1; step(); w_done = 0;
        steps(3);
        chk("en_low_no_sof", 32'(r0_sof), 32'h0);
        chk("en_low_w_cnt", 32'(w_frame_cnt), 32'h3);
        enable = 1; step();
        chk("en_high_r0_sof", 32'(r0_sof), 32'h1);
        r0_req = 0; step();
        r0_done = 1; step(); r0_done = 0;

        // Reset with every channel mid-frame.
        w_req = 1; r0_req = 1; r1_req = 1;
        steps(7);
        chk("all_busy", 32'({r1_busy, r0_busy, w_busy}), 32'b111);
        w_req = 0; r0_req = 0; r1_req = 0;
        reset = 1; step(); reset = 0;
        chk("rst_mid_busy", 32'({r1_busy, r0_busy, w_busy}), 32'h0);
        chk("rst_mid_err", 32'(err), 32'h0);
        chk("rst_mid_cnt", 32'({w_frame_cnt, r0_frame_cnt, r1_frame_cnt}), 32'h0);
        chk("rst_mid_fv", 32'(frame_valid), 32'h0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            reset   = ($urandom_range(0, 399) == 0);
            enable  = ($urandom_range(0, 7) != 0);
            w_req   = $urandom_range(0, 1) != 0;
            r0_req  = $urandom_range(0, 1) != 0;
            r1_req  = $urandom_range(0, 1) != 0;
            w_done  = ($urandom_range(0, 5) == 0);
            r0_done = ($urandom_range(0, 7) == 0);
            r1_done = ($urandom_range(0, 11) == 0);
            err_clr = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter C_TIMEOUT, default 1000000, meaning max cycles a channel may stay BUSY before forced abort.
REQ-002 SHALL have parameter C_CNT_WIDTH, default 32, meaning width of the completed-frame counters.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  high permits new frame starts.
REQ-006 SHALL have ports w_req, r0_req, r1_req  in  1 each  level: requester ready to begin a frame.
REQ-007 SHALL have ports w_done, r0_done, r1_done  in  1 each  one-cycle pulse: requester finished its frame.
REQ-008 SHALL have ports w_sof, r0_sof, r1_sof  out  1 each  one-cycle start-of-frame pulse to the mutex buffer pool and requester.
REQ-009 SHALL have ports w_busy, r0_busy, r1_busy  out  1 each  channel in BUSY.
REQ-010 SHALL have port frame_valid  out  1  at least one writer frame completed since reset.
REQ-011 SHALL have port err  out  3  sticky timeout flags {r1,r0,w}.
REQ-012 SHALL have port err_clr  in  3  per-bit clear of err.
REQ-013 SHALL have ports w_frame_cnt, r0_frame_cnt, r1_frame_cnt  out  C_CNT_WIDTH each  completed frames per channel, wrapping.

Function
REQ-014 Each channel SHALL run an FSM with states IDLE, SOF, BUSY.
REQ-015 IDLE->SOF SHALL occur when req high, enable high, channel eligible, channel granted; SOF lasts exactly one cycle, then BUSY.
REQ-016 sof output SHALL be high only in SOF, i.e. the cycle after req is sampled with grant (latency 1).
REQ-017 BUSY->IDLE SHALL occur on done; done in IDLE or SOF SHALL be ignored.
REQ-018 Writer SHALL always be eligible; readers SHALL be eligible only while frame_valid is high.
REQ-019 At most one channel SHALL enter SOF per cycle; writer SHALL have priority; between readers, round-robin with last-granted reader lowest priority, initial pointer favouring r0.
REQ-020 A channel SHALL NOT enter SOF while any channel is in SOF (sof pulses at least two cycles apart).
REQ-021 done and req in the same BUSY cycle SHALL return to IDLE only; re-issue earliest one cycle later.
REQ-022 enable low SHALL block new SOF only; BUSY frames SHALL complete normally.
REQ-023 frame_valid SHALL set on the first writer BUSY->IDLE via done and stay set until reset.
REQ-024 frame counters SHALL increment by 1 on each done-terminated BUSY, wrapping modulo 2^C_CNT_WIDTH.
REQ-025 A per-channel counter SHALL count BUSY cycles; at C_TIMEOUT the channel SHALL return to IDLE, set its err bit, and NOT increment its frame counter.
REQ-026 err bit set and err_clr same cycle SHALL leave the bit set.

Reset
REQ-027 On reset all FSMs SHALL be IDLE; sof, busy, err, frame_valid, counters SHALL be 0; round-robin pointer SHALL favour r0.
REQ-028 Reset mid-frame SHALL abort all frames without setting err or counting.

Structure
REQ-029 FSM state encoding and channel index constants SHALL reside in shared package frame_sched_pkg.
REQ-030 Per-channel FSM plus timeout and frame counter SHALL be sub-module frame_sched_chan, instantiated three times; arbitration stays in top.

Verification
REQ-031 Reset, r0_req=1 held, no writer activity -> r0_sof never asserts, frame_valid=0.
REQ-032 w_req=1 -> w_sof at next cycle; w_done 10 cycles later -> frame_valid=1, w_frame_cnt=1.
REQ-033 After frame_valid, w_req, r0_req, r1_req all raised same cycle -> w_sof, then r0_sof two cycles later, then r1_sof two cycles after that.
REQ-034 C_TIMEOUT=16, r1 BUSY without done -> r1 IDLE after 16 cycles, err=3'b100, r1_frame_cnt unchanged; err_clr=3'b100 -> err=0.
REQ-035 enable=0 with w BUSY and r0_req high -> no r0_sof; w_done still counted; enable=1 -> r0_sof next eligible cycle.
REQ-036 reset asserted with all channels BUSY -> all busy=0, err=0, counters=0 the cycle after.
